// File: rtl/ctrl_pkg.sv
// Shared opcode, ALU-op encodings and control bundle type for the ID->EX control stage.
package ctrl_pkg;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_RFN = 2'b10;
  localparam logic [1:0] ALUOP_IFN = 2'b11;

  typedef struct packed {
    logic       branch;
    logic       mem_read;
    logic       mem_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam int unsigned CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/control_pipe_stage_if.sv
// Upstream/downstream handshake and registered control bundle of the ID->EX stage.
interface control_pipe_stage_if #(
  parameter int unsigned CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      instruction;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic             branch;
  logic             mem_read;
  logic             mem_reg;
  logic             mem_write;
  logic             alu_src;
  logic             reg_write;
  logic [1:0]       ALU_op;
  logic [4:0]       rd;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic             illegal;
  logic [CNT_W-1:0] bubble_cnt;

  // The stage itself.
  modport slave (
    input  in_valid, instruction, flush, out_ready,
    output in_ready, out_valid, branch, mem_read, mem_reg, mem_write, alu_src, reg_write,
    output ALU_op, rd, rs1, rs2, illegal, bubble_cnt
  );

  // Decode/EX side driving the stage.
  modport master (
    output in_valid, instruction, flush, out_ready,
    input  in_ready, out_valid, branch, mem_read, mem_reg, mem_write, alu_src, reg_write,
    input  ALU_op, rd, rs1, rs2, illegal, bubble_cnt
  );
endinterface

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: control bundle, illegal flag and rs2 usage.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter bit EXT_OPCODES = 1'b1
) (
  input  logic [6:0] opcode,
  output ctrl_t      ctrl,
  output logic       illegal,
  output logic       uses_rs2
);

  always_comb begin
    ctrl     = '0;
    illegal  = 1'b0;
    uses_rs2 = 1'b0;
    case (opcode)
      OPC_R: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALUOP_RFN;
        uses_rs2       = 1'b1;
      end
      OPC_LOAD: begin
        ctrl.mem_read  = 1'b1;
        ctrl.mem_reg   = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALUOP_ADD;
      end
      OPC_STORE: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALUOP_ADD;
        uses_rs2       = 1'b1;
      end
      OPC_BRANCH: begin
        ctrl.branch = 1'b1;
        ctrl.alu_op = ALUOP_SUB;
        uses_rs2    = 1'b1;
      end
      OPC_OPIMM: begin
        if (EXT_OPCODES) begin
          ctrl.alu_src   = 1'b1;
          ctrl.reg_write = 1'b1;
          ctrl.alu_op    = ALUOP_IFN;
        end else begin
          illegal = 1'b1;
        end
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_pipe_stage.sv
// ID->EX control pipeline register with opcode decode, load-use bubble insertion and a
// saturating bubble counter.
module control_pipe_stage
  import ctrl_pkg::*;
#(
  parameter bit          EXT_OPCODES = 1'b1,
  parameter bit          ENABLE_HAZ  = 1'b1,
  parameter int unsigned CNT_W       = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  control_pipe_stage_if.slave bus
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  ctrl_t            dec_ctrl;
  logic             dec_illegal;
  logic             dec_uses_rs2;
  logic [4:0]       in_rd, in_rs1, in_rs2;
  logic             hazard;
  logic             in_ready;

  logic             valid_q, valid_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic             illegal_q, illegal_d;
  logic [4:0]       rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  ctrl_decode #(
    .EXT_OPCODES (EXT_OPCODES)
  ) u_decode (
    .opcode   (bus.instruction[6:0]),
    .ctrl     (dec_ctrl),
    .illegal  (dec_illegal),
    .uses_rs2 (dec_uses_rs2)
  );

  assign in_rd  = bus.instruction[11:7];
  assign in_rs1 = bus.instruction[19:15];
  assign in_rs2 = bus.instruction[24:20];

  logic unused_instr_bits;
  assign unused_instr_bits = ^{bus.instruction[31:25], bus.instruction[14:12]};

  // A bubble (valid_q=0) or a load to x0 can never create a load-use dependency.
  assign hazard = ENABLE_HAZ && bus.in_valid && valid_q && ctrl_q.mem_read &&
                  (rd_q != 5'd0) &&
                  ((rd_q == in_rs1) || (dec_uses_rs2 && (rd_q == in_rs2)));

  assign in_ready = bus.flush || ((!valid_q || bus.out_ready) && !hazard);

  always_comb begin
    valid_d   = valid_q;
    ctrl_d    = ctrl_q;
    illegal_d = illegal_q;
    rd_d      = rd_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    cnt_d     = cnt_q;
    if (bus.flush) begin
      valid_d   = 1'b0;
      ctrl_d    = '0;
      illegal_d = 1'b0;
    end else if (valid_q && !bus.out_ready) begin
      // EX is back-pressuring: hold everything.
    end else if (hazard) begin
      valid_d   = 1'b0;
      ctrl_d    = '0;
      illegal_d = 1'b0;
      if (cnt_q != CntMax) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (bus.in_valid && in_ready) begin
      valid_d   = 1'b1;
      ctrl_d    = dec_ctrl;
      illegal_d = dec_illegal;
      rd_d      = in_rd;
      rs1_d     = in_rs1;
      rs2_d     = in_rs2;
    end else begin
      valid_d   = 1'b0;
      ctrl_d    = '0;
      illegal_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      ctrl_q    <= '0;
      illegal_q <= 1'b0;
      rd_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      cnt_q     <= '0;
    end else begin
      valid_q   <= valid_d;
      ctrl_q    <= ctrl_d;
      illegal_q <= illegal_d;
      rd_q      <= rd_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = valid_q;
  assign bus.branch     = ctrl_q.branch;
  assign bus.mem_read   = ctrl_q.mem_read;
  assign bus.mem_reg    = ctrl_q.mem_reg;
  assign bus.mem_write  = ctrl_q.mem_write;
  assign bus.alu_src    = ctrl_q.alu_src;
  assign bus.reg_write  = ctrl_q.reg_write;
  assign bus.ALU_op     = ctrl_q.alu_op;
  assign bus.rd         = rd_q;
  assign bus.rs1        = rs1_q;
  assign bus.rs2        = rs2_q;
  assign bus.illegal    = illegal_q;
  assign bus.bubble_cnt = cnt_q;

endmodule
